// File: rtl/pipeline_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package pipeline_lsu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned IDX_W     = 30;
    localparam int unsigned LANES     = 4;
    localparam int unsigned DEPTH_DEF = 32;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_e;

    // Context captured in the read half of a sub-word store.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  word;
        logic [LANES-1:0] mask;
        logic [XLEN-1:0]  data;
    } rmw_ctx_t;

    function automatic logic is_store(lsu_op_e op);
        return (op == SW) || (op == SH) || (op == SB);
    endfunction

    function automatic logic is_sub_word(lsu_op_e op);
        return (op != LW) && (op != SW);
    endfunction

    function automatic logic is_half(lsu_op_e op);
        return (op == LH) || (op == LHU) || (op == SH);
    endfunction

endpackage

// File: rtl/pipeline_lsu_if.sv
// Word-addressed data memory bus; the LSU is the master.
interface pipeline_lsu_if;
    import pipeline_lsu_pkg::*;

    logic            o_mem_read;
    logic            o_mem_write;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wdata;
    logic [XLEN-1:0] i_mem_rdata;

    modport master (
        output o_mem_read,
        output o_mem_write,
        output o_mem_addr,
        output o_mem_wdata,
        input  i_mem_rdata
    );

    modport slave (
        input  o_mem_read,
        input  o_mem_write,
        input  o_mem_addr,
        input  o_mem_wdata,
        output i_mem_rdata
    );

endinterface

// File: rtl/pipeline_lsu_align.sv
// Lane steering: load extraction/extension, store lane merge, alignment check.
module pipeline_lsu_align
    import pipeline_lsu_pkg::*;
(
    input  lsu_op_e          op,
    input  logic [1:0]       byte_off,
    input  logic [XLEN-1:0]  load_word,
    input  logic [XLEN-1:0]  store_data,
    input  logic [XLEN-1:0]  rmw_word,
    input  logic [LANES-1:0] rmw_mask,
    input  logic [XLEN-1:0]  rmw_data,
    output logic             misaligned_c,
    output logic [XLEN-1:0]  load_data_c,
    output logic [LANES-1:0] store_mask_c,
    output logic [XLEN-1:0]  store_rep_c,
    output logic [XLEN-1:0]  merged_c
);

    logic [XLEN-1:0] lane_word;

    // Word ops need offset 0, half ops need an even offset.
    always_comb begin
        misaligned_c = 1'b0;
        if (!is_sub_word(op)) begin
            misaligned_c = (byte_off != 2'b00);
        end else if (is_half(op)) begin
            misaligned_c = byte_off[0];
        end
    end

    // Little-endian lane select then sign/zero extension.
    always_comb begin
        lane_word   = load_word >> {byte_off, 3'b000};
        load_data_c = load_word;
        case (op)
            LB:      load_data_c = {{24{lane_word[7]}}, lane_word[7:0]};
            LBU:     load_data_c = {24'h0, lane_word[7:0]};
            LH:      load_data_c = {{16{lane_word[15]}}, lane_word[15:0]};
            LHU:     load_data_c = {16'h0, lane_word[15:0]};
            default: load_data_c = load_word;
        endcase
    end

    // Replicate store data across lanes so the mask alone picks the target.
    always_comb begin
        store_mask_c = 4'b1111;
        store_rep_c  = store_data;
        case (op)
            SB: begin
                store_mask_c = 4'b0001 << byte_off;
                store_rep_c  = {4{store_data[7:0]}};
            end
            SH: begin
                store_mask_c = 4'b0011 << byte_off;
                store_rep_c  = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Byte-wise merge of captured store data into the captured word.
    always_comb begin
        merged_c = rmw_word;
        for (int b = 0; b < int'(LANES); b++) begin
            if (rmw_mask[b]) begin
                merged_c[8*b +: 8] = rmw_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/pipeline_lsu.sv
// MEM-stage load/store unit: alignment/range check, sub-word RMW, registered load data.
module pipeline_lsu
    import pipeline_lsu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  lsu_op_e          i_op,
    input  logic [XLEN-1:0]  i_addr,
    input  logic [XLEN-1:0]  i_wdata,
    output logic             o_stall,
    output logic [XLEN-1:0]  o_rdata,
    output logic             o_rdata_valid,
    output logic             o_fault,
    output logic [XLEN-1:0]  o_fault_addr,
    pipeline_lsu_if.master   mem
);

    lsu_state_e       state_q;
    lsu_state_e       state_d;
    rmw_ctx_t         rmw_q;

    logic [IDX_W-1:0] word_idx_c;
    logic             out_of_range_c;
    logic             misaligned_c;
    logic             req_c;
    logic             fault_c;
    logic             accept_c;
    logic             load_c;
    logic             rmw_start_c;
    logic [XLEN-1:0]  load_data_c;
    logic [LANES-1:0] store_mask_c;
    logic [XLEN-1:0]  store_rep_c;
    logic [XLEN-1:0]  merged_c;

    pipeline_lsu_align u_align (
        .op           (i_op),
        .byte_off     (i_addr[1:0]),
        .load_word    (mem.i_mem_rdata),
        .store_data   (i_wdata),
        .rmw_word     (rmw_q.word),
        .rmw_mask     (rmw_q.mask),
        .rmw_data     (rmw_q.data),
        .misaligned_c (misaligned_c),
        .load_data_c  (load_data_c),
        .store_mask_c (store_mask_c),
        .store_rep_c  (store_rep_c),
        .merged_c     (merged_c)
    );

    // Request classification; only IDLE accepts new work.
    always_comb begin
        word_idx_c     = i_addr[XLEN-1:2];
        out_of_range_c = (word_idx_c >= IDX_W'(DEPTH));
        req_c          = i_valid && (state_q == IDLE);
        fault_c        = req_c && (misaligned_c || out_of_range_c);
        accept_c       = req_c && !(misaligned_c || out_of_range_c);
        load_c         = accept_c && !is_store(i_op);
        rmw_start_c    = accept_c && is_store(i_op) && is_sub_word(i_op);
    end

    // State register; reset aborts any pending RMW.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: sub-word stores take one extra write cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rmw_start_c) state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes and stall, decoded from state and the current request.
    always_comb begin
        o_stall         = 1'b0;
        mem.o_mem_read  = 1'b0;
        mem.o_mem_write = 1'b0;
        mem.o_mem_addr  = {2'b00, word_idx_c};
        mem.o_mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (!is_store(i_op)) begin
                        mem.o_mem_read = 1'b1;
                    end else if (is_sub_word(i_op)) begin
                        mem.o_mem_read = 1'b1;
                        o_stall        = 1'b1;
                    end else begin
                        mem.o_mem_write = 1'b1;
                        mem.o_mem_wdata = i_wdata;
                    end
                end
            end
            RMW_WR: begin
                mem.o_mem_write = 1'b1;
                mem.o_mem_addr  = {2'b00, rmw_q.idx};
                mem.o_mem_wdata = merged_c;
            end
            default: ;
        endcase
    end

    // Capture the read word and lane info for the write half of an RMW.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rmw_q <= '0;
        end else if (rmw_start_c) begin
            rmw_q <= '{idx: word_idx_c, word: mem.i_mem_rdata,
                       mask: store_mask_c, data: store_rep_c};
        end
    end

    // MEM/WB result registers and fault reporting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_fault       <= 1'b0;
            o_fault_addr  <= '0;
        end else begin
            o_rdata_valid <= load_c;
            o_fault       <= fault_c;
            if (load_c) begin
                o_rdata <= load_data_c;
            end
            if (fault_c) begin
                o_fault_addr <= i_addr;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_lsu.sv
// Directed and reference-model bench for pipeline_lsu.
module tb_pipeline_lsu;
    import pipeline_lsu_pkg::*;

    localparam int unsigned DEPTH = 32;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    lsu_op_e     i_op;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdata_valid;
    logic        o_fault;
    logic [31:0] o_fault_addr;

    pipeline_lsu_if bus ();

    pipeline_lsu #(.DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_op          (i_op),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_stall       (o_stall),
        .o_rdata       (o_rdata),
        .o_rdata_valid (o_rdata_valid),
        .o_fault       (o_fault),
        .o_fault_addr  (o_fault_addr),
        .mem           (bus)
    );

    always #5 i_clk = ~i_clk;

    // Data memory: combinational read, write at posedge.
    logic [31:0] mem [DEPTH];
    assign bus.i_mem_rdata = (bus.o_mem_read && bus.o_mem_addr < 32'(DEPTH))
                             ? mem[bus.o_mem_addr[4:0]] : 32'h0;
    always @(posedge i_clk) begin
        if (bus.o_mem_write && bus.o_mem_addr < 32'(DEPTH))
            mem[bus.o_mem_addr[4:0]] <= bus.o_mem_wdata;
    end

    int overlap_cnt = 0;
    always @(negedge i_clk) begin
        if (bus.o_mem_read && bus.o_mem_write) overlap_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] r_data;
    logic        r_valid;
    logic        r_fault;
    logic [31:0] r_faddr;
    int          n_stall;
    logic        en_seen;

    // Present one request, hold it while stalled, return after its last posedge (+1).
    task automatic issue(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wd);
        logic st;
        i_valid = 1'b1;
        i_op    = op;
        i_addr  = addr;
        i_wdata = wd;
        n_stall = 0;
        en_seen = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            en_seen = en_seen | bus.o_mem_read | bus.o_mem_write;
            st = o_stall;
            @(posedge i_clk);
            #1;
            if (!st) break;
            n_stall++;
        end
        i_valid = 1'b0;
        r_data  = o_rdata;
        r_valid = o_rdata_valid;
        r_fault = o_fault;
        r_faddr = o_fault_addr;
    endtask

    task automatic idle();
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    logic [31:0] ref_mem [DEPTH];

    function automatic logic [31:0] ref_load(input lsu_op_e op, input logic [31:0] w, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            LB:  return {{24{b[7]}}, b};
            LBU: return {24'h0, b};
            LH:  return {{16{h[15]}}, h};
            LHU: return {16'h0, h};
            default: return w;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] snap0, snap1, snap8;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_op    = LW;
        i_addr  = 32'h0;
        i_wdata = 32'h0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_rvalid", 32'(o_rdata_valid), 32'h0);
        check("rst_fault", 32'(o_fault), 32'h0);
        check("rst_faddr", o_fault_addr, 32'h0);
        check("rst_stall", 32'(o_stall), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Byte/half loads from a stored word, back to back.
        issue(SW, 32'h8, 32'h11223344);
        check("sw8_mem", mem[2], 32'h11223344);
        issue(LB, 32'h9, 32'h0);
        check("lb9", r_data, 32'h00000033);
        check("lb9_valid", 32'(r_valid), 32'h1);
        issue(LBU, 32'hB, 32'h0);
        check("lbu_b", r_data, 32'h00000011);
        issue(LH, 32'hA, 32'h0);
        check("lh_a", r_data, 32'h00001122);
        idle();
        check("rvalid_pulse", 32'(o_rdata_valid), 32'h0);

        // Sign vs zero extension.
        issue(SW, 32'h4, 32'h000000F0);
        issue(LB, 32'h4, 32'h0);
        check("lb4_sext", r_data, 32'hFFFFFFF0);
        issue(LH, 32'h4, 32'h0);
        check("lh4", r_data, 32'h000000F0);
        issue(LBU, 32'h4, 32'h0);
        check("lbu4", r_data, 32'h000000F0);

        // Sub-word read-modify-write.
        issue(SW, 32'h10, 32'hAABBCCDD);
        issue(SB, 32'h12, 32'h00000055);
        check("sb_stall_cycles", 32'(n_stall), 32'd1);
        issue(LW, 32'h10, 32'h0);
        check("lw_after_sb", r_data, 32'hAA55CCDD);
        issue(SH, 32'h10, 32'h00001234);
        check("sh_stall_cycles", 32'(n_stall), 32'd1);
        issue(LW, 32'h10, 32'h0);
        check("lw_after_sh", r_data, 32'hAA551234);
        issue(LH, 32'h12, 32'h0);
        check("lh_hi_sext", r_data, 32'hFFFFAA55);

        // Faults: misaligned word, misaligned half, out of range.
        snap0 = mem[0];
        snap1 = mem[1];
        issue(LW, 32'h6, 32'h0);
        check("flt_lw6", 32'(r_fault), 32'h1);
        check("flt_lw6_addr", r_faddr, 32'h6);
        check("flt_lw6_en", 32'(en_seen), 32'h0);
        check("flt_lw6_valid", 32'(r_valid), 32'h0);
        issue(SH, 32'h3, 32'hDEAD);
        check("flt_sh3", 32'(r_fault), 32'h1);
        check("flt_sh3_addr", r_faddr, 32'h3);
        check("flt_sh3_en", 32'(en_seen), 32'h0);
        check("flt_sh3_stall", 32'(n_stall), 32'h0);
        issue(LW, 32'h80, 32'h0);
        check("flt_oor", 32'(r_fault), 32'h1);
        check("flt_oor_addr", r_faddr, 32'h80);
        check("flt_oor_en", 32'(en_seen), 32'h0);
        check("flt_mem0", mem[0], snap0);
        check("flt_mem1", mem[1], snap1);
        idle();
        check("fault_pulse", 32'(o_fault), 32'h0);
        check("faddr_hold", o_fault_addr, 32'h80);
        issue(SW, 32'h7C, 32'h0BADF00D);
        issue(LW, 32'h7C, 32'h0);
        check("last_word_nofault", 32'(r_fault), 32'h0);
        check("last_word_data", r_data, 32'h0BADF00D);

        // Reset during the write half of an RMW.
        issue(SW, 32'h20, 32'h01020304);
        issue(LW, 32'h20, 32'h0);
        snap8 = mem[8];
        i_valid = 1'b1;
        i_op    = SB;
        i_addr  = 32'h20;
        i_wdata = 32'h99;
        #1;
        check("rst_sb_stall", 32'(o_stall), 32'h1);
        @(posedge i_clk);
        #1;
        check("rst_rmw_wr", 32'(bus.o_mem_write), 32'h1);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        check("rst_abort_wr", 32'(bus.o_mem_write), 32'h0);
        @(posedge i_clk);
        #1;
        check("rst_mem_keep", mem[8], snap8);
        check("rst2_rdata", o_rdata, 32'h0);
        check("rst2_rvalid", 32'(o_rdata_valid), 32'h0);
        check("rst2_fault", 32'(o_fault), 32'h0);
        check("rst2_faddr", o_fault_addr, 32'h0);
        check("rst2_stall", 32'(o_stall), 32'h0);
        check("rst2_rd", 32'(bus.o_mem_read), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        issue(LW, 32'h20, 32'h0);
        check("post_rst_lw", r_data, 32'h01020304);
        check("post_rst_valid", 32'(r_valid), 32'h1);

        // Random stream against a reference memory.
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i] = $urandom();
            issue(SW, 32'(i) << 2, ref_mem[i]);
        end
        for (int n = 0; n < 300; n++) begin
            lsu_op_e     op;
            int unsigned idx;
            logic [1:0]  off;
            logic [31:0] addr, wd;
            logic        exp_flt;
            op   = lsu_op_e'(3'($urandom_range(0, 7)));
            idx  = ($urandom_range(0, 9) == 0) ? $urandom_range(32, 40) : $urandom_range(0, 31);
            off  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            addr = (32'(idx) << 2) | {30'h0, off};
            wd   = $urandom();
            exp_flt = (idx >= DEPTH)
                      || ((op == LW || op == SW) && off != 2'd0)
                      || ((op == LH || op == LHU || op == SH) && off[0]);
            issue(op, addr, wd);
            check("rnd_fault", 32'(r_fault), 32'(exp_flt));
            if (!exp_flt) begin
                if (!is_store(op)) begin
                    check("rnd_load", r_data, ref_load(op, ref_mem[idx], off));
                end else if (op == SW) begin
                    ref_mem[idx] = wd;
                end else if (op == SH) begin
                    if (off[1]) ref_mem[idx][31:16] = wd[15:0];
                    else        ref_mem[idx][15:0]  = wd[15:0];
                end else begin
                    case (off)
                        2'd0: ref_mem[idx][7:0]   = wd[7:0];
                        2'd1: ref_mem[idx][15:8]  = wd[7:0];
                        2'd2: ref_mem[idx][23:16] = wd[7:0];
                        default: ref_mem[idx][31:24] = wd[7:0];
                    endcase
                end
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            issue(LW, 32'(i) << 2, 32'h0);
            check("rnd_final_lw", r_data, ref_mem[i]);
        end

        check("rw_overlap", 32'(overlap_cnt), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_lsu.md
# pipeline_lsu

Load/store unit for the MEM stage of the pipelined MIPS32 core; it is the initiator side of the word-addressed data memory. It translates byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB requests into whole-word memory accesses and checks alignment and range. Sub-word stores use a two-cycle read-modify-write sequence, and the unit stalls the pipeline for that sequence. Load results are registered for the MEM/WB boundary.

## Interface
- DEPTH, 32, data memory size in 32-bit words; word index must be < DEPTH.
- i_clk  in  1  rising-edge clock, shared with data memory.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  request present this cycle.
- i_op  in  3  operation code (package enum).
- i_addr  in  32  byte address.
- i_wdata  in  32  store data; byte/half taken from the low bits.
- o_stall  out  1  pipeline must hold MEM-stage inputs this cycle.
- o_rdata  out  32  registered load result, extended per op.
- o_rdata_valid  out  1  one-cycle pulse, o_rdata updated.
- o_fault  out  1  one-cycle pulse, misaligned or out-of-range request.
- o_fault_addr  out  32  i_addr of last faulting request.
- o_mem_read  out  1  memory read enable.
- o_mem_write  out  1  memory write enable (written at posedge).
- o_mem_addr  out  32  word index, i_addr >> 2.
- o_mem_wdata  out  32  word to write.
- i_mem_rdata  in  32  combinational memory read data; zero when o_mem_read=0.

## Operation
- FSM states: IDLE, RMW_WR.
- Fault check happens in IDLE when i_valid=1:
  - Misaligned: word ops with i_addr[1:0]≠0, or half ops with i_addr[0]=1.
  - Out-of-range: i_addr[31:2] ≥ DEPTH.
  - On fault: no memory enables are asserted, o_fault pulses next cycle, and o_fault_addr is captured.
- Loads (IDLE): o_mem_read=1. The lane is selected by i_addr[1:0]; big-endian lane order is not used, so byte 0 = bits [7:0]. The lane is sign- or zero-extended per op and registered into o_rdata. o_rdata_valid pulses next cycle. State stays IDLE.
- SW (IDLE): o_mem_write=1, o_mem_wdata=i_wdata. Completes in one cycle.
- SH/SB (IDLE):
  - Cycle 1: o_mem_read=1 and o_stall=1. The read word, lane mask, i_wdata and word index are captured. Go to RMW_WR.
  - Cycle 2, RMW_WR: o_mem_write=1, o_mem_addr is the captured index, and o_mem_wdata is the captured word with the selected lane replaced. o_stall=0. i_valid is ignored, because the pipeline is still presenting the same store. Return to IDLE.
- o_mem_read and o_mem_write are never asserted together.
- i_valid=0 in IDLE: no enables, no pulses.
- Reset asserted: state goes to IDLE, and every output register goes to 0 (o_rdata, o_rdata_valid, o_fault, o_fault_addr). A pending RMW is aborted and no write occurs.

## Timing
- Load latency: 1 cycle from request to o_rdata_valid.
- SW: the memory is updated at the same posedge the request is presented.
- SH/SB: 2 cycles, with o_stall high in the first cycle only. The memory is updated at the second posedge.
- Fault pulse: 1 cycle after the request.
- o_stall and the memory outputs are combinational from state and inputs. o_rdata, o_rdata_valid, o_fault and o_fault_addr are registered.
- A back-to-back load issued right after RMW_WR sees the newly written word.

## Structure
- pipeline_lsu_pkg holds:
  - The op enum: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
  - The FSM state typedef.
  - Helper functions is_store and is_sub_word.
- Sub-module pipeline_lsu_align is purely combinational. It does load lane extraction and extension, store lane merge, and the misalignment check. The FSM, capture registers and output registers stay in pipeline_lsu.

## Test plan
- Write 0x11223344 to byte address 0x8 with SW, then LB@0x9, LBU@0xB, LH@0xA → o_rdata = 0x00000033, 0x00000011, 0x00001122 on consecutive cycles.
- Write word 0x000000F0 at address 0x4, then LB@0x4 → 0xFFFFFFF0; LH@0x4 → 0x000000F0.
- Word 0xAABBCCDD at 0x10, then SB 0x55@0x12 → o_stall high for exactly 1 cycle; a subsequent LW@0x10 returns 0xAA55CCDD. Then SH 0x1234@0x10 → LW returns 0xAA551234.
- LW@0x6, SH@0x3 and LW@0x80 (DEPTH=32) → o_fault pulses each time and o_fault_addr matches. No o_mem_write/o_mem_read is asserted, and memory contents are unchanged.
- Drop i_rst_n in the RMW_WR cycle of SB@0x20 → no write; the word at 0x20 is unchanged; all outputs are 0; the next LW works normally.
- Random op/address stream against a reference memory model → every load matches the model, and o_mem_read and o_mem_write are never both high.
